rv_control_decoder: RTL and testbench
=====================================

# rv_control_decoder

Combinational instruction decoder for the single-cycle RV32I CPU datapath. It takes the fetched 32-bit instruction and produces every datapath control select and write enable. These cover immediate format, ALU operand sources, ALU operation, branch signedness, write-back source, and the register/memory/CSR write enables. It sits between instruction memory and the datapath muxes, regfile, data memory and CSR unit.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; single clock domain; no decode state is clocked.
- rst_n  input  1  reset, asynchronous, active-low.
- inst  input  32  current instruction.
- pc  input  32  PC of `inst`; reserved, does not affect any output.
- reg_wen  output  1  regfile write enable.
- imm_sel  output  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 CSR zimm.
- br_un  output  1  branch compare unsigned.
- a_sel  output  2  ALU A: 0 rs1, 1 PC, 2 zero, 3 reserved (treat as 0).
- b_sel  output  2  ALU B: 0 rs2, 1 immediate, 2–3 reserved (treat as 0).
- alu_sel  output  4  ALU op, encoded as {bit30, funct3}, listed below.
- mem_wen  output  1  data memory write enable.
- wb_sel  output  2  write-back source: 0 ALU, 1 memory, 2 PC+4, 3 reserved.
- csr_sel  output  1  CSR write data: 0 rs1, 1 zimm.
- csr_wen  output  1  CSR write enable.

## Operation
ALU encodings:
- ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.

Decode by opcode `inst[6:0]`. Defaults: all enables 0, all selects 0.
- R-type (0110011): reg_wen 1, a 0, b 0, imm 000, alu {inst[30], funct3}, wb 0.
- I-arith (0010011): reg_wen 1, a 0, b 1, imm 000, wb 0.
  - alu is {inst[30], funct3} only when funct3 = 101 (SRLI/SRAI).
  - Otherwise alu is {0, funct3}, so ADDI never decodes to SUB.
- Load (0000011): reg_wen 1, a 0, b 1, imm 000, alu ADD, wb 1.
- Store (0100011): mem_wen 1, reg_wen 0, a 0, b 1, imm 001, alu ADD.
- Branch (1100011): reg_wen 0, a 1, b 1, imm 010, alu ADD, br_un = funct3[1] (1 for BLTU/BGEU).
- JAL (1101111): reg_wen 1, a 1, b 1, imm 100, alu ADD, wb 2.
- JALR (1100111): reg_wen 1, a 0, b 1, imm 000, alu ADD, wb 2.
- LUI (0110111): reg_wen 1, a 2, b 1, imm 011, alu ADD, wb 0.
- AUIPC (0010111): reg_wen 1, a 1, b 1, imm 011, alu ADD, wb 0.
- SYSTEM (1110011), funct3 001 (CSRRW) or 101 (CSRRWI):
  - csr_wen 1, csr_sel = funct3[2], reg_wen 0.
  - imm 101 when funct3[2] = 1, else 000.
- SYSTEM with any other funct3: all enables 0.
- br_un is 0 for every non-branch opcode.
- Unknown opcode decodes as a NOP: all outputs 0.
- rd = x0 does not suppress reg_wen; the regfile discards x0 writes.
- While rst_n = 0, reg_wen, mem_wen and csr_wen are forced to 0 asynchronously. All other outputs keep decoding `inst`.

## Timing
- Purely combinational from `inst` (and rst_n for the enable gating). Zero-cycle latency; outputs valid within the same cycle.
- No internal state. clk is connected but unused; no output depends on a clock edge.
- Reset value of every output: reg_wen, mem_wen and csr_wen are 0. All other outputs equal the decode of the current `inst`.
- Release of rst_n re-enables the write enables immediately, with no clock needed.
- Changing `pc` alone changes no output.

## Test plan
- ADDI 0x00200013 -> imm 000, alu 0000, a 0, b 1, wb 0, reg_wen 1. SRAI 0x4030D093 -> alu 1101.
- JALR 0x008100E7 -> imm 000, alu 0000, a 0, b 1, wb 2, reg_wen 1.
- ADD 0x00308133 -> imm 000, alu 0000, a 0, b 0, wb 0. SUB 0x40308133 -> alu 1000.
- JAL 0x008000EF -> imm 100, alu 0000, a 1, b 1, wb 2, reg_wen 1.
- Branches:
  - BEQ 0x00310863 -> imm 010, a 1, b 1, alu 0000, reg_wen 0, br_un 0.
  - BLTU 0x02316063 -> same selects, br_un 1.
- Other opcodes and reset:
  - SW 0x00112223 -> mem_wen 1, imm 001, a 0, b 1, reg_wen 0.
  - LW 0x00412083 -> wb 1, reg_wen 1.
  - LUI 0x123450B7 -> a 2, imm 011.
  - CSRRW 0x51E09073 -> csr_wen 1, csr_sel 0. CSRRWI 0x51E2D073 -> csr_wen 1, csr_sel 1, imm 101.
  - 0x0000007F -> all outputs 0.
  - rst_n = 0 with ADD -> reg_wen 0.

Source files
------------

// File: rtl/rv_control_decoder.sv
// RV32I control decoder: maps the current instruction onto datapath selects and write enables.
// Purely combinational; rst_n only gates the three write enables.
module rv_control_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic        reg_wen,
    output logic [2:0]  imm_sel,
    output logic        br_un,
    output logic [1:0]  a_sel,
    output logic [1:0]  b_sel,
    output logic [3:0]  alu_sel,
    output logic        mem_wen,
    output logic [1:0]  wb_sel,
    output logic        csr_sel,
    output logic        csr_wen
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;

    logic       reg_wen_d;
    logic       mem_wen_d;
    logic       csr_wen_d;

    // clk and pc are part of the datapath-facing interface but never steer decode.
    logic unused_inputs;
    assign unused_inputs = ^{clk, pc};

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign bit30  = inst[30];

    always_comb begin
        reg_wen_d = 1'b0;
        mem_wen_d = 1'b0;
        csr_wen_d = 1'b0;
        imm_sel   = IMM_I;
        br_un     = 1'b0;
        a_sel     = 2'd0;
        b_sel     = 2'd0;
        alu_sel   = ALU_ADD;
        wb_sel    = 2'd0;
        csr_sel   = 1'b0;

        unique case (opcode)
            OP_R: begin
                reg_wen_d = 1'b1;
                alu_sel   = {bit30, funct3};
            end
            OP_IARITH: begin
                reg_wen_d = 1'b1;
                b_sel     = 2'd1;
                // bit30 only distinguishes SRLI/SRAI; for ADDI it is immediate data.
                alu_sel   = (funct3 == 3'b101) ? {bit30, funct3} : {1'b0, funct3};
            end
            OP_LOAD: begin
                reg_wen_d = 1'b1;
                b_sel     = 2'd1;
                wb_sel    = 2'd1;
            end
            OP_STORE: begin
                mem_wen_d = 1'b1;
                b_sel     = 2'd1;
                imm_sel   = IMM_S;
            end
            OP_BRANCH: begin
                a_sel   = 2'd1;
                b_sel   = 2'd1;
                imm_sel = IMM_B;
                br_un   = funct3[1];
            end
            OP_JAL: begin
                reg_wen_d = 1'b1;
                a_sel     = 2'd1;
                b_sel     = 2'd1;
                imm_sel   = IMM_J;
                wb_sel    = 2'd2;
            end
            OP_JALR: begin
                reg_wen_d = 1'b1;
                b_sel     = 2'd1;
                wb_sel    = 2'd2;
            end
            OP_LUI: begin
                reg_wen_d = 1'b1;
                a_sel     = 2'd2;
                b_sel     = 2'd1;
                imm_sel   = IMM_U;
            end
            OP_AUIPC: begin
                reg_wen_d = 1'b1;
                a_sel     = 2'd1;
                b_sel     = 2'd1;
                imm_sel   = IMM_U;
            end
            OP_SYSTEM: begin
                // Only CSRRW/CSRRWI are supported; every other SYSTEM op is a NOP.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    csr_wen_d = 1'b1;
                    csr_sel   = funct3[2];
                    imm_sel   = funct3[2] ? IMM_Z : IMM_I;
                end
            end
            default: begin
            end
        endcase
    end

    assign reg_wen = reg_wen_d & rst_n;
    assign mem_wen = mem_wen_d & rst_n;
    assign csr_wen = csr_wen_d & rst_n;

endmodule

// File: tb/tb_rv_control_decoder.sv
// Bench for rv_control_decoder: vector table through a scoreboard queue, plus async-reset and pc sequences.
module tb_rv_control_decoder;

    typedef struct packed {
        logic       reg_wen;
        logic [2:0] imm_sel;
        logic       br_un;
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [3:0] alu_sel;
        logic       mem_wen;
        logic [1:0] wb_sel;
        logic       csr_sel;
        logic       csr_wen;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        rst_n;
        out_t        exp;
    } vec_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        reg_wen;
    logic [2:0]  imm_sel;
    logic        br_un;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [3:0]  alu_sel;
    logic        mem_wen;
    logic [1:0]  wb_sel;
    logic        csr_sel;
    logic        csr_wen;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];
    sb_t  sb[$];

    rv_control_decoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inst    (inst),
        .pc      (pc),
        .reg_wen (reg_wen),
        .imm_sel (imm_sel),
        .br_un   (br_un),
        .a_sel   (a_sel),
        .b_sel   (b_sel),
        .alu_sel (alu_sel),
        .mem_wen (mem_wen),
        .wb_sel  (wb_sel),
        .csr_sel (csr_sel),
        .csr_wen (csr_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic rw, input logic [2:0] imm, input logic bu,
                                input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu,
                                input logic mw, input logic [1:0] wb, input logic cs, input logic cw);
        out_t o;
        o.reg_wen = rw;
        o.imm_sel = imm;
        o.br_un   = bu;
        o.a_sel   = a;
        o.b_sel   = b;
        o.alu_sel = alu;
        o.mem_wen = mw;
        o.wb_sel  = wb;
        o.csr_sel = cs;
        o.csr_wen = cw;
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.reg_wen = reg_wen;
        o.imm_sel = imm_sel;
        o.br_un   = br_un;
        o.a_sel   = a_sel;
        o.b_sel   = b_sel;
        o.alu_sel = alu_sel;
        o.mem_wen = mem_wen;
        o.wb_sel  = wb_sel;
        o.csr_sel = csr_sel;
        o.csr_wen = csr_wen;
        return o;
    endfunction

    task automatic add_vec(input string name, input logic [31:0] i, input logic r, input out_t e);
        vec_t v;
        v.name  = name;
        v.inst  = i;
        v.rst_n = r;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    // Pops the oldest expectation and compares it against the live outputs.
    task automatic check_pop();
        sb_t  s;
        out_t got;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        s   = sb.pop_front();
        got = dut_out();
        n_checks++;
        if (got !== s.exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (rw imm bu a b alu mw wb cs cw)", s.name, got, s.exp);
        end else begin
            $display("ok   %s: inst=%h outputs=%b", s.name, inst, got);
        end
    endtask

    task automatic drive(input string name, input logic [31:0] i, input logic r, input out_t e);
        sb_t s;
        inst  = i;
        rst_n = r;
        s.name = name;
        s.exp  = e;
        sb.push_back(s);
        #1;
        check_pop();
    endtask

    initial begin
        out_t add_exp;
        rst_n = 1'b0;
        inst  = 32'h0000_0013;
        pc    = 32'h0;

        //          name        inst          rst  rw imm    bu a     b     alu      mw wb    cs cw
        add_vec("addi",      32'h00200013, 1, mk(1, 3'b000, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("addi_b30",  32'h40000093, 1, mk(1, 3'b000, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("srai",      32'h4030D093, 1, mk(1, 3'b000, 0, 2'd0, 2'd1, 4'b1101, 0, 2'd0, 0, 0));
        add_vec("sltiu",     32'h0010B093, 1, mk(1, 3'b000, 0, 2'd0, 2'd1, 4'b0011, 0, 2'd0, 0, 0));
        add_vec("jalr",      32'h008100E7, 1, mk(1, 3'b000, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd2, 0, 0));
        add_vec("add",       32'h00308133, 1, mk(1, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("sub",       32'h40308133, 1, mk(1, 3'b000, 0, 2'd0, 2'd0, 4'b1000, 0, 2'd0, 0, 0));
        add_vec("sra",       32'h4030D0B3, 1, mk(1, 3'b000, 0, 2'd0, 2'd0, 4'b1101, 0, 2'd0, 0, 0));
        add_vec("and",       32'h0030F0B3, 1, mk(1, 3'b000, 0, 2'd0, 2'd0, 4'b0111, 0, 2'd0, 0, 0));
        add_vec("jal",       32'h008000EF, 1, mk(1, 3'b100, 0, 2'd1, 2'd1, 4'b0000, 0, 2'd2, 0, 0));
        add_vec("beq",       32'h00310863, 1, mk(0, 3'b010, 0, 2'd1, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("bne",       32'h00311063, 1, mk(0, 3'b010, 0, 2'd1, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("bltu",      32'h02316063, 1, mk(0, 3'b010, 1, 2'd1, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("bgeu",      32'h0031F063, 1, mk(0, 3'b010, 1, 2'd1, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("sw",        32'h00112223, 1, mk(0, 3'b001, 0, 2'd0, 2'd1, 4'b0000, 1, 2'd0, 0, 0));
        add_vec("lw",        32'h00412083, 1, mk(1, 3'b000, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd1, 0, 0));
        add_vec("lui",       32'h123450B7, 1, mk(1, 3'b011, 0, 2'd2, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("auipc",     32'h00000097, 1, mk(1, 3'b011, 0, 2'd1, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("csrrw",     32'h51E09073, 1, mk(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 1));
        add_vec("csrrwi",    32'h51E2D073, 1, mk(0, 3'b101, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 1, 1));
        add_vec("csrrs_nop", 32'h51E0A073, 1, mk(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("ecall_nop", 32'h00000073, 1, mk(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("unknown",   32'h0000007F, 1, mk(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("rst_add",   32'h00308133, 0, mk(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("rst_sw",    32'h00112223, 0, mk(0, 3'b001, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        add_vec("rst_jal",   32'h008000EF, 0, mk(0, 3'b100, 0, 2'd1, 2'd1, 4'b0000, 0, 2'd2, 0, 0));
        add_vec("rst_csrwi", 32'h51E2D073, 0, mk(0, 3'b101, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 1, 0));

        repeat (2) @(posedge clk);
        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            pc = $urandom;
            drive(vecs[k].name, vecs[k].inst, vecs[k].rst_n, vecs[k].exp);
        end

        // Reset assert/release mid-cycle, away from any clock edge.
        add_exp = mk(1, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0);
        @(posedge clk);
        #2;
        drive("async_pre", 32'h00308133, 1'b1, add_exp);
        #1;
        drive("async_assert", 32'h00308133, 1'b0, mk(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
        drive("async_release", 32'h00308133, 1'b1, add_exp);

        // pc alone must not move any output.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            pc = $urandom;
            drive("pc_only_sw", 32'h00112223, 1'b1, mk(0, 3'b001, 0, 2'd0, 2'd1, 4'b0000, 1, 2'd0, 0, 0));
        end

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
